// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared phase codes, state type and sizing constants for the SNN core
package snn_pkg;

  localparam int N_NUM = 32;
  localparam int G_NUM = 4;
  localparam int N_SZ  = $clog2(N_NUM);
  localparam int G_SZ  = $clog2(G_NUM);
  localparam int GS_W  = 2 * G_NUM;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_SET      = 3'b001,
    ST_SYN_ACCU = 3'b010,
    ST_DECAY    = 3'b011,
    ST_PDE      = 3'b100,
    ST_FINISH   = 3'b101,
    ST_DONE     = 3'b110
  } state_t;

endpackage

// File: rtl/snn_step_ctrl_if.sv
// rtl/snn_step_ctrl_if.sv - run control, SRAM, synapse and PDE signals of the timestep sequencer
interface snn_step_ctrl_if #(
  parameter int G_NUM  = snn_pkg::G_NUM,
  parameter int STEP_W = 8,
  parameter int IDX_W  = 2
);
  logic                  start;
  logic [STEP_W-1:0]     num_steps;
  logic [G_NUM-1:0]      gs_code_0;
  logic [G_NUM-1:0]      gs_code_1;
  logic                  gs_valid;
  logic                  syn_ready;
  logic [2:0]            state;
  logic                  sram_access;
  logic                  shift_en;
  logic [2*G_NUM-1:0]    syn_en;
  logic                  syn_valid;
  logic                  decay_en;
  logic                  pde_en;
  logic [IDX_W-1:0]      pde_idx;
  logic [STEP_W-1:0]     step_cnt;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, num_steps, gs_code_0, gs_code_1, gs_valid, syn_ready,
    output state, sram_access, shift_en, syn_en, syn_valid, decay_en, pde_en,
           pde_idx, step_cnt, busy, done
  );

  modport slave (
    output start, num_steps, gs_code_0, gs_code_1, gs_valid, syn_ready,
    input  state, sram_access, shift_en, syn_en, syn_valid, decay_en, pde_en,
           pde_idx, step_cnt, busy, done
  );
endinterface

// File: rtl/snn_step_ctrl_syn_pick.sv
// rtl/snn_step_ctrl_syn_pick.sv - one-hot highest set bit of a group mask plus any-bit flag
module syn_pick
  import snn_pkg::*;
#(
  parameter int W = GS_W
) (
  input  logic [W-1:0] mask,
  output logic [W-1:0] onehot,
  output logic         any
);
  // Ascending scan: the last hit wins, so the highest group is selected.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < W; i++) begin
      if (mask[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    any = |mask;
  end
endmodule

// File: rtl/snn_step_ctrl.sv
// rtl/snn_step_ctrl.sv - SNN timestep sequencer: SET, SYN_ACCU, DECAY, PDE, FINISH per step
// Optional build macro SNN_SKIP_EMPTY_EN: an empty group mask skips SYN_ACCU entirely.
module snn_step_ctrl
  import snn_pkg::*;
#(
  parameter int N_NUM     = snn_pkg::N_NUM,
  parameter int G_NUM     = snn_pkg::G_NUM,
  parameter int PDE_LANES = 8,
  parameter int DECAY_CYC = 2,
  parameter int STEP_W    = 8,
  localparam int W        = 2 * G_NUM,
  localparam int PDE_BLK  = N_NUM / PDE_LANES,
  localparam int IDX_W    = (PDE_BLK > 1) ? $clog2(PDE_BLK) : 1,
  localparam int DC_W     = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  snn_step_ctrl_if.master   bus
);
  state_t            st;
  logic [W-1:0]      mask;
  logic [W-1:0]      gs_cat;
  logic [W-1:0]      pick_in;
  logic [W-1:0]      pick_oh;
  logic              pick_any;
  logic [STEP_W-1:0] num_lat;
  logic [STEP_W-1:0] step_nxt;
  logic [DC_W-1:0]   dcnt;

  assign gs_cat   = {bus.gs_code_0, bus.gs_code_1};
  // In SET the picker looks at the incoming code; afterwards at the mask minus the granted group.
  assign pick_in  = (st == ST_SET) ? gs_cat : (mask & ~bus.syn_en);
  assign step_nxt = bus.step_cnt + 1'b1;
  assign bus.state = st;

  syn_pick #(.W(W)) u_pick (
    .mask   (pick_in),
    .onehot (pick_oh),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st              <= ST_IDLE;
      mask            <= '0;
      num_lat         <= '0;
      dcnt            <= '0;
      bus.sram_access <= 1'b0;
      bus.shift_en    <= 1'b0;
      bus.syn_en      <= '0;
      bus.syn_valid   <= 1'b0;
      bus.decay_en    <= 1'b0;
      bus.pde_en      <= 1'b0;
      bus.pde_idx     <= '0;
      bus.step_cnt    <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.shift_en <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (bus.start) begin
            num_lat      <= bus.num_steps;
            bus.step_cnt <= '0;
            if (bus.num_steps == '0) begin
              st       <= ST_DONE;
              bus.done <= 1'b1;
            end else begin
              st              <= ST_SET;
              bus.sram_access <= 1'b1;
              bus.busy        <= 1'b1;
            end
          end
        end
        ST_SET: begin
          if (bus.gs_valid) begin
            mask            <= gs_cat;
            bus.sram_access <= 1'b0;
            bus.shift_en    <= 1'b1;
`ifdef SNN_SKIP_EMPTY_EN
            if (!pick_any) begin
              st           <= ST_DECAY;
              bus.decay_en <= 1'b1;
              dcnt         <= '0;
            end else
`endif
            begin
              st            <= ST_SYN_ACCU;
              bus.syn_en    <= pick_oh;
              bus.syn_valid <= pick_any;
            end
          end
        end
        ST_SYN_ACCU: begin
          if (!bus.syn_valid || bus.syn_ready) begin
            mask          <= pick_in;
            bus.syn_en    <= pick_oh;
            bus.syn_valid <= pick_any;
            if (!pick_any) begin
              st           <= ST_DECAY;
              bus.decay_en <= 1'b1;
              dcnt         <= '0;
            end
          end
        end
        ST_DECAY: begin
          if (dcnt == DC_W'(DECAY_CYC - 1)) begin
            st           <= ST_PDE;
            bus.decay_en <= 1'b0;
            bus.pde_en   <= 1'b1;
            bus.pde_idx  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_PDE: begin
          if (bus.pde_idx == IDX_W'(PDE_BLK - 1)) begin
            st          <= ST_FINISH;
            bus.pde_en  <= 1'b0;
            bus.pde_idx <= '0;
          end else begin
            bus.pde_idx <= bus.pde_idx + 1'b1;
          end
        end
        ST_FINISH: begin
          bus.step_cnt <= step_nxt;
          if (step_nxt == num_lat) begin
            st       <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            st              <= ST_SET;
            bus.sram_access <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.start) begin
            st       <= ST_IDLE;
            bus.done <= 1'b0;
          end
        end
        default: begin
          st              <= ST_IDLE;
          mask            <= '0;
          bus.sram_access <= 1'b0;
          bus.syn_en      <= '0;
          bus.syn_valid   <= 1'b0;
          bus.decay_en    <= 1'b0;
          bus.pde_en      <= 1'b0;
          bus.pde_idx     <= '0;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snn_step_ctrl.sv
// tb/tb_snn_step_ctrl.sv - randomized self-checking bench for snn_step_ctrl with a step-level model
module tb_snn_step_ctrl;
  import snn_pkg::*;

  localparam int PDE_BLK = 32 / 8;
  localparam int DECAY_N = 2;
`ifdef SNN_SKIP_EMPTY_EN
  localparam int EMPTY_SYN = 0;
`else
  localparam int EMPTY_SYN = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snn_step_ctrl_if bus ();
  snn_step_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int       vectors = 0;
  int       errors  = 0;
  logic [7:0] step_mask [8];
  int       step_delay [8];
  int       ready_pct;
  int       stall_first;
  bit       hold_start;
  bit       pulse_start;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {4'h0, bus.state, bus.sram_access, bus.shift_en, bus.syn_en, bus.syn_valid,
            bus.decay_en, bus.pde_en, bus.pde_idx, bus.step_cnt, bus.busy, bus.done};
  endfunction

  // Step-level model: each step is SET (delay+1 cycles), groups granted high bit first,
  // DECAY_N decay cycles, PDE_BLK indexed PDE cycles, one FINISH cycle.
  task automatic run_case(input int nsteps);
    int step, set_cyc, syn_cyc, stalls, dec_cyc, pde_cyc, done_cyc, stall_left, exp_syn;
    logic [7:0] q[$];
    logic [2:0] prev;
    bit finished, rdy, busy_st;
    step = 0; set_cyc = 0; syn_cyc = 0; stalls = 0; dec_cyc = 0; pde_cyc = 0; done_cyc = 0;
    stall_left = stall_first;
    prev = ST_IDLE;
    finished = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_steps = 8'(nsteps);
    @(negedge clk);
    bus.num_steps = 8'($urandom);
    if (!hold_start) bus.start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      busy_st = !(bus.state == ST_IDLE || bus.state == ST_DONE);
      check_eq("busy", bus.busy, busy_st);
      check_eq("shift_en", bus.shift_en, prev == ST_SET && bus.state != ST_SET);
      check_eq("sram_access", bus.sram_access, bus.state == ST_SET);
      check_eq("decay_en", bus.decay_en, bus.state == ST_DECAY);
      check_eq("pde_en", bus.pde_en, bus.state == ST_PDE);
      check_eq("done", bus.done, bus.state == ST_DONE);
      bus.gs_valid  = 1'b0;
      bus.gs_code_0 = 4'($urandom);
      bus.gs_code_1 = 4'($urandom);
      rdy = ($urandom_range(0, 99) < ready_pct);
      if (pulse_start && busy_st) bus.start = ($urandom_range(0, 3) == 0);
      case (bus.state)
        ST_SET: begin
          if (prev != ST_SET) begin
            set_cyc = 0;
            q.delete();
            for (int b = 7; b >= 0; b--) if (step_mask[step][b]) q.push_back(8'(1 << b));
            check_eq("step_cnt_set", bus.step_cnt, step);
          end
          if (set_cyc == step_delay[step]) begin
            bus.gs_valid = 1'b1;
            {bus.gs_code_0, bus.gs_code_1} = step_mask[step];
          end
          set_cyc++;
        end
        ST_SYN_ACCU: begin
          syn_cyc++;
          check_eq("syn_valid", bus.syn_valid, q.size() != 0);
          check_eq("syn_en", bus.syn_en, (q.size() != 0) ? q[0] : 8'h00);
          if (q.size() != 0) begin
            if (stall_left > 0) begin
              rdy = 1'b0;
              stall_left--;
            end
            if (rdy) void'(q.pop_front());
            else stalls++;
          end
        end
        ST_DECAY: dec_cyc++;
        ST_PDE: begin
          check_eq("pde_idx", bus.pde_idx, pde_cyc);
          pde_cyc++;
        end
        ST_FINISH: begin
          check_eq("set_cycles", set_cyc, step_delay[step] + 1);
          exp_syn = (step_mask[step] == 8'h00) ? EMPTY_SYN : $countones(step_mask[step]) + stalls;
          check_eq("syn_cycles", syn_cyc, exp_syn);
          check_eq("grants_left", q.size(), 0);
          check_eq("decay_cycles", dec_cyc, DECAY_N);
          check_eq("pde_cycles", pde_cyc, PDE_BLK);
          check_eq("step_cnt_fin", bus.step_cnt, step);
          step++;
          syn_cyc = 0; stalls = 0; dec_cyc = 0; pde_cyc = 0;
        end
        ST_DONE: begin
          check_eq("step_cnt_done", bus.step_cnt, nsteps);
          check_eq("steps_run", step, nsteps);
          done_cyc++;
          bus.start = hold_start && (done_cyc < 3);
        end
        ST_IDLE: begin
          finished = 1;
          check_eq("done_cycles", done_cyc, hold_start ? 3 : 1);
          check_eq("step_cnt_idle", bus.step_cnt, nsteps);
        end
        default: check_eq("state_legal", bus.state, ST_IDLE);
      endcase
      bus.syn_ready = rdy;
      prev = bus.state;
      @(negedge clk);
    end
    check_eq("run_finished", finished, 1'b1);
    bus.start = 1'b0;
    bus.gs_valid = 1'b0;
    bus.syn_ready = 1'b0;
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_steps = 8'd2;
    bus.syn_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.gs_valid = 1'b1;
    {bus.gs_code_0, bus.gs_code_1} = 8'hFF;
    for (int i = 0; i < 20 && bus.state != ST_SYN_ACCU; i++) @(negedge clk);
    bus.gs_valid = 1'b0;
    check_eq("pre_reset_state", bus.state, ST_SYN_ACCU);
    #2 rst = 1'b0;
    #1 check_eq("rst_async_outs", all_outs(), 32'h0);
    @(negedge clk);
    check_eq("rst_held_outs", all_outs(), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.gs_code_0 = '0;
    bus.gs_code_1 = '0;
    bus.gs_valid = 1'b0;
    bus.syn_ready = 1'b0;
    #12 check_eq("reset_outs", all_outs(), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    ready_pct = 100; stall_first = 0; hold_start = 1; pulse_start = 0;
    step_mask[0] = 8'hA1; step_delay[0] = 0;
    run_case(1);

    step_mask[0] = 8'h81; stall_first = 3;
    run_case(1);

    step_mask[0] = 8'h00; stall_first = 0;
    run_case(1);

    for (int i = 0; i < 3; i++) begin
      step_mask[i] = 8'($urandom_range(1, 255));
      step_delay[i] = 5;
    end
    run_case(3);

    run_case(0);

    hold_start = 0; pulse_start = 1; ready_pct = 70;
    for (int i = 0; i < 2; i++) begin
      step_mask[i] = 8'($urandom);
      step_delay[i] = $urandom_range(0, 3);
    end
    run_case(2);

    reset_mid_run();
    hold_start = 1; pulse_start = 0; ready_pct = 100;
    step_mask[0] = 8'hA1; step_delay[0] = 0;
    run_case(1);

    repeat (10) begin
      for (int i = 0; i < 8; i++) begin
        step_mask[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        step_delay[i] = $urandom_range(0, 4);
      end
      ready_pct = $urandom_range(30, 100);
      stall_first = $urandom_range(0, 2);
      hold_start = 1'($urandom);
      pulse_start = !hold_start && ($urandom_range(0, 1) == 1);
      run_case($urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/snn_step_ctrl.md
Name: snn_step_ctrl

Overview:
- Top-level timestep sequencer for the SNN core.
- Drives the shared 3-bit phase code (IDLE/SET/SYN_ACCU/DECAY/PDE/FINISH/DONE) seen by the group-arrangement, synapse-accumulate, decay and potential/spike-detect (PDE) datapaths.
- Loads per-timestep group spike codes from SRAM, then schedules the active synapse groups one per handshake.
- Steps decay and PDE, and repeats for a programmed number of timesteps.

Parameters:
- N_NUM, 32, neurons in the core.
- G_NUM, 4, groups per GS code half; the combined code is 2*G_NUM bits.
- PDE_LANES, 8, neurons processed per PDE cycle; N_NUM must be a multiple of it.
- DECAY_CYC, 2, cycles spent in DECAY (>=1).
- STEP_W, 8, timestep counter width.

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- start  in  1  level; run request, sampled in IDLE
- num_steps  in  STEP_W  timesteps to run; latched on start
- gs_code_0  in  G_NUM  group spike code, upper half
- gs_code_1  in  G_NUM  group spike code, lower half
- gs_valid  in  1  SRAM read data valid
- syn_ready  in  1  accumulator accepts a group
- state  out  3  current phase code
- sram_access  out  1  SRAM read request
- shift_en  out  1  one-cycle pulse: new GS code loaded
- syn_en  out  2*G_NUM  one-hot active group
- syn_valid  out  1  syn_en valid
- decay_en  out  1  decay strobe
- pde_en  out  1  PDE strobe
- pde_idx  out  clog2(N_NUM/PDE_LANES)  PDE lane-block index
- step_cnt  out  STEP_W  completed timesteps
- busy  out  1  state not IDLE/DONE
- done  out  1  run complete

Behaviour:
- Interface: one clock, clk. rst is asynchronous, active-low; assertion forces IDLE and clears all outputs and registers immediately, including mid-run. Release is synchronous to clk.
- Reset values: state=000; all other outputs 0.
- Encodings: IDLE 000, SET 001, SYN_ACCU 010, DECAY 011, PDE 100, FINISH 101, DONE 110. Codes 111 are unreachable; if entered, go to IDLE.
- All outputs are registered.
- IDLE:
  - start=1 latches num_steps and clears step_cnt.
  - num_steps=0 goes directly to DONE; otherwise go to SET.
- SET:
  - sram_access=1 until the gs_valid cycle.
  - On gs_valid, capture mask = {gs_code_0, gs_code_1}.
  - shift_en pulses exactly one cycle, the cycle after capture; state goes to SYN_ACCU in the same cycle.
  - While gs_valid=0, stay in SET with no timeout.
- SYN_ACCU:
  - syn_en is the highest set bit of the remaining mask (bit 2*G_NUM-1 first); syn_valid=1 while mask != 0.
  - On syn_valid & syn_ready, clear that bit. The next group is presented the following cycle, so sustained throughput is one group per cycle.
  - syn_en and syn_valid stay stable while syn_ready=0.
  - After the final handshake, go to DECAY with syn_valid=0.
  - Empty mask: see Optional Feature.
- DECAY: decay_en=1 for exactly DECAY_CYC cycles, then go to PDE.
- PDE:
  - pde_en=1 for N_NUM/PDE_LANES cycles; pde_idx counts 0..N_NUM/PDE_LANES-1.
  - pde_idx returns to 0 on exit; then go to FINISH.
- FINISH:
  - One cycle; step_cnt increments.
  - If the incremented value equals the latched num_steps, go to DONE; otherwise go to SET.
- DONE:
  - done=1 and step_cnt hold until start=0, then go to IDLE.
  - done clears on IDLE entry.
- start is ignored outside IDLE and DONE. Changes to num_steps after latch are ignored.

Optional Feature:
- Macro: SNN_SKIP_EMPTY_EN.
- Defined: a captured mask of 0 goes from SET directly to DECAY, skipping SYN_ACCU; shift_en still pulses.
- Undefined: a captured mask of 0 spends exactly one cycle in SYN_ACCU with syn_valid=0, syn_en=0, then goes to DECAY.

Decomposition:
- Package snn_pkg:
  - The seven phase-code constants and the state type.
  - N_NUM, G_NUM, N_SZ, G_SZ defaults.
  - GS code width constant.
- Sub-module syn_pick (combinational): takes the 2*G_NUM-bit mask and returns the one-hot highest set bit plus an any-bit flag. It is reused by the group-arrangement datapath.

Test Plan:
- Basic run: start with num_steps=1, gs_valid with codes 4'b1010/4'b0001, syn_ready=1.
  - syn_en sequence is 0x80, 0x20, 0x01, one per cycle.
  - decay_en is high 2 cycles; pde_idx steps 0..3.
  - done=1 and step_cnt=1.
- Backpressure: mask 0x81 with syn_ready low for 3 cycles on the first group.
  - syn_en holds 0x80 for 4 cycles, then 0x01 appears the next cycle.
- Empty mask, both macro settings:
  - Defined: SET goes to DECAY, with the shift_en pulse observed.
  - Undefined: exactly one SYN_ACCU cycle with syn_valid=0.
- Multi-step: num_steps=3, with gs_valid delayed 5 cycles per step.
  - Three SET entries; step_cnt reads 1, 2, 3; DONE after the third FINISH.
  - done clears only after start drops.
- Edge cases:
  - num_steps=0 goes IDLE to DONE in one cycle with no sram_access.
  - A start pulse mid-run has no effect.
- Reset: assert rst mid-SYN_ACCU, between clock edges.
  - All outputs are 0 and state=000 before the next clk edge.
  - A new run after release behaves as the basic run.
